// File: rtl/prg_mem_pkg.sv
// rtl/prg_mem_pkg.sv - shared types and constants for the program memory port
package prg_mem_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_MON = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        VFY  = 2'd3
    } state_t;

endpackage

// File: rtl/prg_mem_port_sync_edge.sv
// rtl/prg_mem_port_sync_edge.sv - multi-stage synchroniser with rising-edge detect
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/prg_mem_port.sv
// rtl/prg_mem_port.sv - monitor/CPU program RAM port; optional PRG_WRITE_VERIFY_EN read-back check
module prg_mem_port
    import prg_mem_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int READ_LAT    = 1,
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic          prg_clock_i,
    input  logic [AW-1:0] prg_ma_i,
    input  logic [DW-1:0] prg_wd_i,
    input  logic          prg_we_i,
    output logic [DW-1:0] prg_rd_o,
    input  logic          cpu_reset_i,
    input  logic          clock_1_i,
    output logic          cpu_clk_en_o,
    input  logic [AW-1:0] cpu_addr_i,
    output logic [DW-1:0] cpu_rd_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wd_o,
    output logic          mem_we_o,
    input  logic [DW-1:0] mem_rd_i,
    output logic          busy_o,
`ifdef PRG_WRITE_VERIFY_EN
    output logic          verify_err_o,
`endif
    output logic          overrun_o
);

    localparam int BW = AW + DW + 2;

    // Data buses share one synchroniser pipe so they stay aligned with the strobe.
    logic [BW-1:0] bus_pipe [SYNC_STAGES];
    logic [BW-1:0] bus_sync;
    logic [AW-1:0] ma_sync;
    logic [DW-1:0] wd_sync;
    logic          we_sync;
    logic          rst_sync;
    logic          prg_rise;
    logic          clk1_rise;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;
    logic [AW-1:0] lat_addr, lat_addr_nxt;
    logic [DW-1:0] lat_wd, lat_wd_nxt;
    logic [1:0]    cnt, cnt_nxt;
    logic [DW-1:0] prg_rd, prg_rd_nxt;
    logic          overrun, overrun_nxt;
`ifdef PRG_WRITE_VERIFY_EN
    logic          vfy_err, vfy_err_nxt;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) bus_pipe[i] <= '0;
        end else begin
            bus_pipe[0] <= {prg_we_i, prg_wd_i, prg_ma_i, cpu_reset_i};
            for (int i = 1; i < SYNC_STAGES; i++) bus_pipe[i] <= bus_pipe[i-1];
        end
    end

    assign bus_sync = bus_pipe[SYNC_STAGES-1];
    assign {we_sync, wd_sync, ma_sync, rst_sync} = bus_sync;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_prg_edge (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .d     (prg_clock_i),
        .rise  (prg_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk1_edge (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .d     (clock_1_i),
        .rise  (clk1_rise)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= IDLE;
            owner    <= OWNER_CPU;
            lat_addr <= '0;
            lat_wd   <= '0;
            cnt      <= '0;
            prg_rd   <= '0;
            overrun  <= 1'b0;
`ifdef PRG_WRITE_VERIFY_EN
            vfy_err  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            lat_addr <= lat_addr_nxt;
            lat_wd   <= lat_wd_nxt;
            cnt      <= cnt_nxt;
            prg_rd   <= prg_rd_nxt;
            overrun  <= overrun_nxt;
`ifdef PRG_WRITE_VERIFY_EN
            vfy_err  <= vfy_err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        lat_addr_nxt = lat_addr;
        lat_wd_nxt   = lat_wd;
        cnt_nxt      = cnt;
        prg_rd_nxt   = prg_rd;
        overrun_nxt  = overrun;
        mem_we_o     = 1'b0;
`ifdef PRG_WRITE_VERIFY_EN
        vfy_err_nxt  = vfy_err;
`endif
        if (prg_rise && state != IDLE) overrun_nxt = 1'b1;

        case (state)
            IDLE: begin
                // Ownership is only re-evaluated here so an access never changes hands mid-flight.
                owner_nxt = rst_sync ? OWNER_MON : OWNER_CPU;
                cnt_nxt   = '0;
                if (prg_rise && owner == OWNER_MON) begin
                    lat_addr_nxt = ma_sync;
                    lat_wd_nxt   = wd_sync;
                    state_nxt    = we_sync ? WR : RD;
                end
            end
            WR: begin
                mem_we_o = 1'b1;
`ifdef PRG_WRITE_VERIFY_EN
                state_nxt = VFY;
`else
                state_nxt = IDLE;
`endif
            end
            RD: begin
                if (cnt == 2'(READ_LAT)) begin
                    prg_rd_nxt = mem_rd_i;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
`ifdef PRG_WRITE_VERIFY_EN
            VFY: begin
                if (cnt == 2'(READ_LAT)) begin
                    if (mem_rd_i != lat_wd) vfy_err_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o       = (state != IDLE);
    assign mem_addr_o   = (owner == OWNER_MON) ? lat_addr : cpu_addr_i;
    assign mem_wd_o     = lat_wd;
    assign prg_rd_o     = prg_rd;
    assign overrun_o    = overrun;
    assign cpu_rd_o     = mem_rd_i;
    assign cpu_clk_en_o = clk1_rise & ~rst_sync;
`ifdef PRG_WRITE_VERIFY_EN
    assign verify_err_o = vfy_err;
`endif

endmodule

// File: tb/tb_prg_mem_port.sv
// tb/tb_prg_mem_port.sv - scoreboard bench for prg_mem_port with RAM and reference memory models
module tb_prg_mem_port;

    localparam int SS = 2;
    localparam int RL = 1;
`ifdef PRG_WRITE_VERIFY_EN
    localparam int   WLEN    = RL + 2;
    localparam logic [7:0] CORRUPT = 8'h01;
`else
    localparam int   WLEN    = 1;
    localparam logic [7:0] CORRUPT = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prg_clock_i, prg_we_i, cpu_reset_i, clock_1_i;
    logic [7:0] prg_ma_i, prg_wd_i, cpu_addr_i, mem_rd_i;
    logic [7:0] prg_rd_o, cpu_rd_o, mem_addr_o, mem_wd_o;
    logic       cpu_clk_en_o, mem_we_o, busy_o, overrun_o;
`ifdef PRG_WRITE_VERIFY_EN
    logic       verify_err_o;
`endif

    always #5 clk = ~clk;

    prg_mem_port #(.SYNC_STAGES(SS), .READ_LAT(RL), .AW(8), .DW(8)) dut (
`ifdef PRG_WRITE_VERIFY_EN
        .verify_err_o  (verify_err_o),
`endif
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .prg_clock_i   (prg_clock_i),
        .prg_ma_i      (prg_ma_i),
        .prg_wd_i      (prg_wd_i),
        .prg_we_i      (prg_we_i),
        .prg_rd_o      (prg_rd_o),
        .cpu_reset_i   (cpu_reset_i),
        .clock_1_i     (clock_1_i),
        .cpu_clk_en_o  (cpu_clk_en_o),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_rd_o      (cpu_rd_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wd_o      (mem_wd_o),
        .mem_we_o      (mem_we_o),
        .mem_rd_i      (mem_rd_i),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o)
    );

    typedef struct {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] rd;
        int         len;
    } exp_t;

    exp_t       sb[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] ref_mem[256];
    logic [7:0] last_rd = 8'h00;

    function automatic logic [7:0] pat(int i);
        return 8'(i * 7 + 3);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM model: synchronous write, READ_LAT-deep registered read address.
    logic [7:0] ram[256];
    logic [7:0] pipe[RL];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(i);
            for (int i = 0; i < RL; i++) pipe[i] <= 8'h00;
        end else begin
            if (mem_we_o) ram[mem_addr_o] <= mem_wd_o;
            pipe[0] <= mem_addr_o;
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mem_rd_i = ram[pipe[RL-1]] ^ ((pipe[RL-1] == 8'hFF) ? CORRUPT : 8'h00);

    int         blen = 0, we_n = 0, we_total = 0, en_total = 0, en_multi = 0;
    logic       bprev = 1'b0, en_prev = 1'b0;
    logic [7:0] wa, wdat;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we_o) we_total++;
            if (cpu_clk_en_o) en_total++;
            if (cpu_clk_en_o && en_prev) en_multi++;
            en_prev = cpu_clk_en_o;
            if (busy_o) begin
                blen++;
                if (mem_we_o) begin
                    we_n++;
                    wa   = mem_addr_o;
                    wdat = mem_wd_o;
                end
            end else if (bprev) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_access: busy ended with no expected access queued");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("we_pulses", we_n, e.is_wr ? 1 : 0);
                    if (e.is_wr) begin
                        check("wr_addr", wa, e.addr);
                        check("wr_data", wdat, e.data);
                    end
                    check("prg_rd", prg_rd_o, e.rd);
                    check("busy_len", blen, e.len);
                end
                blen = 0;
                we_n = 0;
            end
            bprev = busy_o;
        end
    end

    task automatic access(logic we, logic [7:0] a, logic [7:0] d);
        exp_t e;
        @(posedge clk); #1;
        prg_we_i = we; prg_ma_i = a; prg_wd_i = d;
        @(posedge clk); #1;
        prg_clock_i = 1'b1;
        if (cpu_reset_i) begin
            e.is_wr = we; e.addr = a; e.data = d;
            if (we) begin
                ref_mem[a] = d;
                e.len = WLEN;
            end else begin
                last_rd = ref_mem[a];
                e.len = RL + 1;
            end
            e.rd = last_rd;
            sb.push_back(e);
        end
        repeat (3) @(posedge clk); #1;
        prg_clock_i = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic toggle_clock_1();
        @(posedge clk); #1 clock_1_i = 1'b1;
        repeat (4) @(posedge clk); #1 clock_1_i = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        rst_n = 1'b0; prg_clock_i = 0; prg_we_i = 0; cpu_reset_i = 0; clock_1_i = 0;
        prg_ma_i = 0; prg_wd_i = 0; cpu_addr_i = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_prg_rd", prg_rd_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_we_en", {mem_we_o, cpu_clk_en_o}, 0);
        check("rst_addr", mem_addr_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        cpu_reset_i = 1'b1;
        repeat (6) @(posedge clk);
        base = we_total;
        access(1'b1, 8'h10, 8'hA5);
        check("t1_we_count", we_total - base, 1);
        access(1'b0, 8'h10, 8'h00);
        check("t2_prg_rd", prg_rd_o, 8'hA5);
        access(1'b1, 8'h20, 8'h5A);
        check("t2_hold", prg_rd_o, 8'hA5);

        for (int n = 0; n < 40; n++)
            access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 8'($urandom));
        check("no_overrun_yet", overrun_o, 0);

        begin
            exp_t e;
            logic [7:0] a;
            a = 8'($urandom_range(0, 254));
            @(posedge clk); #1 prg_we_i = 0; prg_ma_i = a;
            @(posedge clk); #1 prg_clock_i = 1;
            last_rd = ref_mem[a];
            e.is_wr = 0; e.addr = a; e.data = 0; e.rd = last_rd; e.len = RL + 1;
            sb.push_back(e);
            @(posedge clk); #1 prg_clock_i = 0;
            @(posedge clk); #1 prg_clock_i = 1;
            @(posedge clk); #1 prg_clock_i = 0;
            repeat (12) @(posedge clk);
            check("t4_overrun", overrun_o, 1);
        end

        cpu_reset_i = 1'b0;
        repeat (6) @(posedge clk);
        base = we_total;
        access(1'b1, 8'h33, 8'h77);
        check("t3_no_we", we_total - base, 0);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1 cpu_addr_i = 8'($urandom);
            @(negedge clk);
            check("t3_addr_follow", mem_addr_o, cpu_addr_i);
            check("t3_cpu_rd", cpu_rd_o, mem_rd_i);
        end
        check("overrun_sticky", overrun_o, 1);

        base = en_total;
        repeat (3) toggle_clock_1();
        repeat (4) @(posedge clk);
        check("t5_en_pulses", en_total - base, 3);
        check("t5_single_cycle", en_multi, 0);
        cpu_reset_i = 1'b1;
        repeat (6) @(posedge clk);
        base = en_total;
        toggle_clock_1();
        check("t5_en_in_reset", en_total - base, 0);

`ifdef PRG_WRITE_VERIFY_EN
        check("t6_vfy_clear", verify_err_o, 0);
        access(1'b1, 8'hFF, 8'h00);
        check("t6_vfy_err", verify_err_o, 1);
`endif

        repeat (5) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
